// File: rtl/cam_cmd_sequencer.sv
// Request FIFO plus single-outstanding CAM op sequencer with a response channel.
// Optional macro CAM_SEQ_WRACK_EN: writes also return a response (op=01, hit=1, data=written data).
module cam_cmd_sequencer #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int FIFO_DEPTH  = 4,
  parameter int CAM_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [1:0]            req_op_i,
  input  logic [ADDR_WIDTH-1:0] req_index_i,
  input  logic [DATA_WIDTH-1:0] req_data_i,
  output logic                  read_o,
  output logic                  write_o,
  output logic                  search_o,
  output logic [ADDR_WIDTH-1:0] read_index_o,
  output logic [ADDR_WIDTH-1:0] write_index_o,
  output logic [DATA_WIDTH-1:0] write_data_o,
  output logic [DATA_WIDTH-1:0] search_data_o,
  input  logic                  read_valid_i,
  input  logic [DATA_WIDTH-1:0] read_value_i,
  input  logic                  search_valid_i,
  input  logic [ADDR_WIDTH-1:0] search_index_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [1:0]            rsp_op_o,
  output logic                  rsp_hit_o,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  err_o,
  output logic [1:0]            state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; a valid payload is held stable until that edge.

  localparam int ENTRY_W = 2 + ADDR_WIDTH + DATA_WIDTH;
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int LAT_W   = (CAM_LATENCY > 1) ? $clog2(CAM_LATENCY) : 1;

  localparam logic [1:0] OP_READ   = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_SEARCH = 2'b10;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2, S_RESP = 2'd3} state_t;

  state_t state_q, state_d;

  logic [ENTRY_W-1:0]    fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  ready_en;
  logic                  push, pop;
  logic [ENTRY_W-1:0]    head;

  logic [1:0]            op_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [LAT_W-1:0]      lat_q;
  logic                  lat_done;

  logic [1:0]            rsp_op_q;
  logic                  rsp_hit_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic                  err_q;

  // ready_en keeps req_ready_o low during reset and until the first clock after it
  assign req_ready_o = ready_en && (count != CNT_W'(FIFO_DEPTH));
  assign push        = req_valid_i && req_ready_o;
  assign pop         = (state_q == S_IDLE) && (count != '0);
  assign head        = fifo_mem[rd_ptr];
  assign lat_done    = (lat_q == LAT_W'(CAM_LATENCY - 1));

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= {req_op_i, req_index_i, req_data_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (count != '0) state_d = S_ISSUE;
      S_ISSUE: begin
        case (op_q)
          OP_READ, OP_SEARCH: state_d = S_WAIT;
`ifdef CAM_SEQ_WRACK_EN
          OP_WRITE:           state_d = S_RESP;
`else
          OP_WRITE:           state_d = S_IDLE;
`endif
          default:            state_d = S_IDLE;
        endcase
      end
      S_WAIT:  if (lat_done) state_d = S_RESP;
      S_RESP:  if (rsp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes and CAM-side buses are decoded from registered state, so reset clears them at once
  assign read_o        = (state_q == S_ISSUE) && (op_q == OP_READ);
  assign write_o       = (state_q == S_ISSUE) && (op_q == OP_WRITE);
  assign search_o      = (state_q == S_ISSUE) && (op_q == OP_SEARCH);
  assign read_index_o  = read_o   ? idx_q  : '0;
  assign write_index_o = write_o  ? idx_q  : '0;
  assign write_data_o  = write_o  ? data_q : '0;
  assign search_data_o = search_o ? data_q : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q       <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      lat_q      <= '0;
      rsp_op_q   <= '0;
      rsp_hit_q  <= 1'b0;
      rsp_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (pop) begin
        op_q   <= head[ENTRY_W-1 -: 2];
        idx_q  <= head[DATA_WIDTH +: ADDR_WIDTH];
        data_q <= head[DATA_WIDTH-1:0];
      end
      if (state_q == S_ISSUE) begin
        lat_q <= '0;
        if (op_q == 2'b11) err_q <= 1'b1;
`ifdef CAM_SEQ_WRACK_EN
        if (op_q == OP_WRITE) begin
          rsp_op_q   <= OP_WRITE;
          rsp_hit_q  <= 1'b1;
          rsp_data_q <= data_q;
        end
`endif
      end
      if (state_q == S_WAIT) begin
        lat_q <= lat_q + LAT_W'(1);
        if (lat_done) begin
          rsp_op_q <= op_q;
          if (op_q == OP_READ) begin
            rsp_hit_q  <= read_valid_i;
            rsp_data_q <= read_value_i;
          end else begin
            rsp_hit_q  <= search_valid_i;
            rsp_data_q <= search_valid_i ? DATA_WIDTH'(search_index_i) : '0;
          end
        end
      end
    end
  end

  assign rsp_valid_o = (state_q == S_RESP);
  assign rsp_op_o    = rsp_op_q;
  assign rsp_hit_o   = rsp_hit_q;
  assign rsp_data_o  = rsp_data_q;
  assign err_o       = err_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_cam_cmd_sequencer.sv
// Bench for cam_cmd_sequencer: behavioural CAM model, request driver, response scoreboard.
`timescale 1ns/1ps
module tb_cam_cmd_sequencer;
  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int FD  = 4;
  localparam int LAT = 2;
  localparam int EW  = 2 + 1 + DW;
  localparam int NE  = 2 ** AW;

  // clock / reset
  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  logic          req_valid_i, req_ready_o;
  logic [1:0]    req_op_i;
  logic [AW-1:0] req_index_i;
  logic [DW-1:0] req_data_i;
  logic          read_o, write_o, search_o;
  logic [AW-1:0] read_index_o, write_index_o;
  logic [DW-1:0] write_data_o, search_data_o;
  logic          read_valid_i;
  logic [DW-1:0] read_value_i;
  logic          search_valid_i;
  logic [AW-1:0] search_index_i;
  logic          rsp_valid_o, rsp_ready_i;
  logic [1:0]    rsp_op_o;
  logic          rsp_hit_o;
  logic [DW-1:0] rsp_data_o;
  logic          err_o;
  logic [1:0]    state_o;

  cam_cmd_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD), .CAM_LATENCY(LAT)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_index_i(req_index_i), .req_data_i(req_data_i),
    .read_o(read_o), .write_o(write_o), .search_o(search_o),
    .read_index_o(read_index_o), .write_index_o(write_index_o),
    .write_data_o(write_data_o), .search_data_o(search_data_o),
    .read_valid_i(read_valid_i), .read_value_i(read_value_i),
    .search_valid_i(search_valid_i), .search_index_i(search_index_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_op_o(rsp_op_o),
    .rsp_hit_o(rsp_hit_o), .rsp_data_o(rsp_data_o), .err_o(err_o), .state_o(state_o)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  bit rand_rdy = 1'b0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h required %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // CAM model: results appear LAT cycles after the strobe, junk otherwise
  logic [DW-1:0] cam_mem [NE] = '{default: '0};
  logic          cam_vld [NE] = '{default: 1'b0};
  logic          p_rd [LAT] = '{default: 1'b0};
  logic          p_sr [LAT] = '{default: 1'b0};
  logic          p_hit [LAT] = '{default: 1'b0};
  logic [DW-1:0] p_val [LAT] = '{default: '0};
  logic [AW-1:0] p_idx [LAT] = '{default: '0};
  logic [DW-1:0] noise = '0;

  function automatic logic [AW:0] cam_find(input logic [DW-1:0] key);
    for (int i = 0; i < NE; i++)
      if (cam_vld[i] && cam_mem[i] == key) return {1'b1, AW'(i)};
    return '0;
  endfunction

  always @(posedge clk) begin
    logic [AW:0] f;
    f = cam_find(search_data_o);
    noise <= $urandom;
    if (write_o) begin
      cam_mem[write_index_o] <= write_data_o;
      cam_vld[write_index_o] <= 1'b1;
    end
    for (int i = LAT - 1; i > 0; i--) begin
      p_rd[i] <= p_rd[i-1]; p_sr[i] <= p_sr[i-1]; p_hit[i] <= p_hit[i-1];
      p_val[i] <= p_val[i-1]; p_idx[i] <= p_idx[i-1];
    end
    p_rd[0] <= read_o;
    p_sr[0] <= search_o;
    if (read_o) begin
      p_hit[0] <= cam_vld[read_index_o];
      p_val[0] <= cam_mem[read_index_o];
    end else begin
      p_hit[0] <= f[AW];
      p_idx[0] <= f[AW] ? f[AW-1:0] : noise[AW-1:0];
    end
  end

  assign read_valid_i   = p_rd[LAT-1] & p_hit[LAT-1];
  assign read_value_i   = p_rd[LAT-1] ? p_val[LAT-1] : noise;
  assign search_valid_i = p_sr[LAT-1] & p_hit[LAT-1];
  assign search_index_i = p_sr[LAT-1] ? p_idx[LAT-1] : noise[AW-1:0];

  // shadow of CAM contents at request time, used to predict responses
  logic [DW-1:0] sh_mem [NE] = '{default: '0};
  logic          sh_vld [NE] = '{default: 1'b0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      if (rand_rdy) rsp_ready_i = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [AW-1:0] idx, input logic [DW-1:0] data,
                      input int max_cyc, output bit acc);
    logic hit;
    logic [DW-1:0] d;
    req_valid_i = 1'b1; req_op_i = op; req_index_i = idx; req_data_i = data;
    acc = 1'b0;
    for (int i = 0; i < max_cyc && !acc; i++) begin
      @(negedge clk);
      acc = req_ready_o;
      tick(1);
    end
    req_valid_i = 1'b0;
    if (acc) begin
      case (op)
        2'b00: exp_q.push_back({2'b00, sh_vld[idx], sh_mem[idx]});
        2'b01: begin
`ifdef CAM_SEQ_WRACK_EN
          exp_q.push_back({2'b01, 1'b1, data});
`endif
          sh_mem[idx] = data;
          sh_vld[idx] = 1'b1;
        end
        2'b10: begin
          hit = 1'b0; d = '0;
          for (int i = NE - 1; i >= 0; i--)
            if (sh_vld[i] && sh_mem[i] == data) begin hit = 1'b1; d = DW'(i); end
          exp_q.push_back({2'b10, hit, d});
        end
        default: ;
      endcase
    end
  endtask

  task automatic put(input logic [1:0] op, input logic [AW-1:0] idx, input logic [DW-1:0] data);
    bit acc;
    send(op, idx, data, 60, acc);
    check("req_accept", acc, 1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 800 && exp_q.size() != 0; i++) tick(1);
    check("drain_pending", exp_q.size(), 0);
    exp_q.delete();
    tick(LAT + 6);
  endtask

  // scoreboard / strobe monitor, sampled on the falling edge
  int n_rd = 0, n_wr = 0, n_sr = 0;
  int last_rd_cyc = 0, rise_cyc = 0;
  logic [AW-1:0] last_wr_idx = '0;
  logic [DW-1:0] last_wr_data = '0;
  logic prev_v = 1'b0;

  always @(negedge clk) begin
    if (!rst_i) begin
      if (read_o)   begin n_rd++; last_rd_cyc = cyc; end
      if (search_o) n_sr++;
      if (write_o)  begin n_wr++; last_wr_idx = write_index_o; last_wr_data = write_data_o; end
      if (read_o || write_o || search_o)
        check("one_strobe", 32'(read_o) + 32'(write_o) + 32'(search_o), 1);
      if (!write_o)  check("wr_bus_quiet", {write_index_o, write_data_o}, 0);
      if (!read_o)   check("rd_bus_quiet", read_index_o, 0);
      if (!search_o) check("sr_bus_quiet", search_data_o, 0);
      if (rsp_valid_o && !prev_v) rise_cyc = cyc;
      if (rsp_valid_o && rsp_ready_i) begin
        check("rsp_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("rsp", {rsp_op_o, rsp_hit_o, rsp_data_o}, exp_q.pop_front());
      end
    end
    prev_v = rsp_valid_o;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int s0;
    rst_i = 1'b1; req_valid_i = 1'b0; req_op_i = '0; req_index_i = '0; req_data_i = '0;
    rsp_ready_i = 1'b1;
    #2;
    check("rst_req_ready", req_ready_o, 0);
    check("rst_rsp", {rsp_valid_o, rsp_op_o, rsp_hit_o, rsp_data_o}, 0);
    check("rst_strobes", {read_o, write_o, search_o, read_index_o, write_index_o}, 0);
    check("rst_err_state", {err_o, state_o}, 0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_i = 1'b0;
    tick(1);
    check("ready_after_rst", req_ready_o, 1);

    // write idx 3
    put(2'b01, 5'd3, 32'hDEADBEEF);
    wait_drain();
    check("wr_pulse_count", n_wr, 1);
    check("wr_index", last_wr_idx, 3);
    check("wr_data", last_wr_data, 32'hDEADBEEF);

    // read idx 3 and its latency
    put(2'b00, 5'd3, '0);
    wait_drain();
    check("rd_latency", rise_cyc - last_rd_cyc, LAT + 1);

    // search hit then miss
    put(2'b10, '0, 32'hDEADBEEF);
    put(2'b10, '0, 32'h12345678);
    wait_drain();

    // back-pressure: one op parked in RESP, FIFO fills with 4, fifth refused
    rsp_ready_i = 1'b0;
    put(2'b00, 5'd3, '0);
    tick(LAT + 6);
    put(2'b10, '0, 32'hDEADBEEF);
    put(2'b01, 5'd5, 32'hA5A50005);
    put(2'b00, 5'd5, '0);
    put(2'b10, '0, 32'hA5A50005);
    send(2'b00, 5'd3, '0, 4, acc);
    check("full_reject", acc, 0);
    check("full_ready_low", req_ready_o, 0);
    repeat (3) begin
      @(negedge clk);
      check("rsp_hold", {rsp_valid_o, rsp_op_o, rsp_hit_o, rsp_data_o}, {1'b1, exp_q[0]});
    end
    tick(1);
    rsp_ready_i = 1'b1;
    put(2'b00, 5'd3, '0);
    wait_drain();

    // illegal op between two reads
    check("err_before", err_o, 0);
    s0 = n_rd + n_wr + n_sr;
    put(2'b00, 5'd3, '0);
    put(2'b11, 5'd7, 32'h0BAD0BAD);
    put(2'b00, 5'd5, '0);
    wait_drain();
    check("illegal_no_strobe", n_rd + n_wr + n_sr - s0, 2);
    check("err_set", err_o, 1);
    tick(5);
    check("err_sticky", err_o, 1);

    // random mix with random response back-pressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0: put(2'b00, AW'($urandom_range(0, 7)), '0);
        1: put(2'b01, AW'($urandom_range(0, 7)), DW'($urandom_range(0, 3)));
        default: put(2'b10, '0, DW'($urandom_range(0, 4)));
      endcase
    end
    rand_rdy = 1'b0;
    rsp_ready_i = 1'b1;
    wait_drain();

    // reset while a read is in WAIT with two more queued
    put(2'b00, 5'd3, '0);
    put(2'b00, 5'd5, '0);
    put(2'b10, '0, 32'hDEADBEEF);
    check("pre_rst_wait", state_o, 2);
    rst_i = 1'b1;
    #1;
    check("rst_mid_outputs", {rsp_valid_o, read_o, write_o, search_o, req_ready_o}, 0);
    check("rst_mid_state", state_o, 0);
    exp_q.delete();
    s0 = n_rd + n_wr + n_sr;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_i = 1'b0;
    tick(12);
    check("rst_fifo_flushed", n_rd + n_wr + n_sr - s0, 0);
    check("rst_err_cleared", err_o, 0);
    check("rst_idle", state_o, 0);
    put(2'b00, 5'd3, '0);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cam_cmd_sequencer.md
Name: cam_cmd_sequencer

Overview:
Front-end stage directly upstream of the CAM. It accepts read/write/search requests over a valid/ready handshake and buffers them in a small FIFO. It issues one CAM operation at a time as single-cycle strobes, captures the CAM's read/search result after a fixed latency, and returns it on a valid/ready response channel.

Parameters:
DATA_WIDTH, 32, CAM entry / search key width
ADDR_WIDTH, 5, CAM index width (CAM depth = 2**ADDR_WIDTH)
FIFO_DEPTH, 4, request FIFO entries; power of 2, >=2
CAM_LATENCY, 1, cycles from CAM strobe to CAM result valid; >=1

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
req_valid_i  in  1  request valid
req_ready_o  out  1  request FIFO can accept
req_op_i  in  2  00 read, 01 write, 10 search, 11 illegal
req_index_i  in  ADDR_WIDTH  read/write index
req_data_i  in  DATA_WIDTH  write data or search key
read_o / write_o / search_o  out  1 each  CAM op strobes
read_index_o / write_index_o  out  ADDR_WIDTH  CAM indices
write_data_o / search_data_o  out  DATA_WIDTH  CAM data/key
read_valid_i  in  1  CAM read result valid
read_value_i  in  DATA_WIDTH  CAM read data
search_valid_i  in  1  CAM search hit
search_index_i  in  ADDR_WIDTH  CAM hit index
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response accepted
rsp_op_o  out  2  op code of the response
rsp_hit_o  out  1  read valid / search hit
rsp_data_o  out  DATA_WIDTH  read value, or hit index zero-extended
err_o  out  1  sticky: illegal op dequeued

Behaviour:
- Reset (async, while rst_i=1): FIFO empty; FSM=IDLE; all strobes 0; all index/data outputs 0; rsp_valid_o=0, rsp_op_o=0, rsp_hit_o=0, rsp_data_o=0; err_o=0; req_ready_o=0 while rst_i=1, 1 from first clock after release.
- Reset mid-operation: any in-flight op is discarded. No response is produced for it.
- FIFO: push when req_valid_i && req_ready_o. req_ready_o = (count != FIFO_DEPTH), taken from the registered count. A pop in the same cycle as a full FIFO does not allow a push that cycle. Read/write pointers wrap modulo FIFO_DEPTH. The stored entry is {op, index, data}.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if FIFO not empty, pop the head into the op register and go to ISSUE. Otherwise stay.
  - ISSUE (1 cycle, cycle T): exactly one strobe is high, with matching index/data driven. Data outputs are 0 when their strobe is low.
    - read/search -> WAIT, latency counter cleared.
    - write -> IDLE.
    - op 11 -> no strobe, err_o<=1, -> IDLE.
  - WAIT: the counter increments each cycle. In cycle T+CAM_LATENCY, capture the result and go to RESP.
    - read: hit=read_valid_i, data=read_value_i.
    - search: hit=search_valid_i, data=hit ? zero-extended search_index_i : 0.
  - RESP: rsp_valid_o=1, with op/hit/data stable until rsp_ready_i=1. On handshake -> IDLE, rsp_valid_o=0 next cycle.
- First response cycle is T+CAM_LATENCY+1. A minimum read costs 3+CAM_LATENCY cycles per op (IDLE, ISSUE, WAIT×CAM_LATENCY, RESP). A write costs 2 cycles.
- Ops complete strictly in FIFO order. Only one CAM op is outstanding at any time.
- Requests may be enqueued during any state, including RESP under back-pressure.

Optional Feature:
CAM_SEQ_WRACK_EN:
- Defined: a write goes ISSUE -> RESP and produces a response with rsp_op_o=01, rsp_hit_o=1, rsp_data_o=written data, under the same handshake rules.
- Undefined: writes produce no response (ISSUE -> IDLE).

Test Plan:
- Reset then write idx 3 = 0xDEADBEEF: write_o pulses 1 cycle with write_index_o=3, write_data_o=0xDEADBEEF. No response (with CAM_SEQ_WRACK_EN: response op=01, hit=1, data=0xDEADBEEF).
- Read idx 3, CAM model returns read_valid_i=1, 0xDEADBEEF at T+CAM_LATENCY: rsp_valid_o rises at T+CAM_LATENCY+1 with op=00, hit=1, data=0xDEADBEEF.
- Search 0xDEADBEEF (hit at 3) then search 0x12345678 (miss): responses in order {op=10, hit=1, data=3}, then {op=10, hit=0, data=0}.
- Hold rsp_ready_i=0 and push 5 requests (FIFO_DEPTH=4): 4 accepted, req_ready_o=0 when full. Response stays stable. Release rsp_ready_i and all ops complete in order.
- Enqueue op=11 between two reads: no strobe for it, err_o=1 and stays 1, both reads respond normally.
- Assert rst_i during WAIT of a read: strobes and rsp_valid_o go 0 immediately, FIFO empties, and no response appears after release.
